// File: rtl/proc_pkg.sv
// Shared definitions for proc_core32: datapath width, register file geometry,
// instruction field positions, opcode/funct encodings and the ALU operation set.
// Optional feature macro: PROC_MUL_EN (adds R-type MUL, funct 0x18).
package proc_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    // Instruction field bit positions
    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 26;
    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;
    localparam int unsigned FN_HI  = 5;
    localparam int unsigned FN_LO  = 0;
    localparam int unsigned IMM_HI = 15;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned TGT_HI = 25;
    localparam int unsigned TGT_LO = 0;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_MUL = 6'h18;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_PASS_B,
        ALU_MUL
    } alu_op_e;

    // Sign-extend a 16-bit immediate to the datapath width
    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for proc_core32.
// Ports:
//   i_a, i_b     operands (i_b[4:0] is the shift amount for shifts)
//   i_alu_op     operation select
//   o_result_c   result
//   o_zero_c     result == 0 (used for BEQ/BNE with a SUB)
// Optional feature macro: PROC_MUL_EN (multiplier only exists when defined).
module proc_alu
    import proc_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_e         i_alu_op,
    output logic [XLEN-1:0] o_result_c,
    output logic            o_zero_c
);

    logic [4:0] w_shamt;

    assign w_shamt = i_b[4:0];

    // Operation mux
    always_comb begin
        o_result_c = '0;
        case (i_alu_op)
            ALU_ADD:    o_result_c = i_a + i_b;
            ALU_SUB:    o_result_c = i_a - i_b;
            ALU_AND:    o_result_c = i_a & i_b;
            ALU_OR:     o_result_c = i_a | i_b;
            ALU_XOR:    o_result_c = i_a ^ i_b;
            ALU_SLT:    o_result_c = XLEN'($signed(i_a) < $signed(i_b));
            ALU_SLL:    o_result_c = i_a << w_shamt;
            ALU_SRL:    o_result_c = i_a >> w_shamt;
            ALU_SRA:    o_result_c = XLEN'($signed(i_a) >>> w_shamt);
            ALU_PASS_B: o_result_c = i_b;
`ifdef PROC_MUL_EN
            ALU_MUL:    o_result_c = i_a * i_b;
`endif
            default:    o_result_c = '0;
        endcase
    end

    assign o_zero_c = (o_result_c == '0);

endmodule

// File: rtl/proc_core32.sv
// Single-cycle 32-bit word-addressed load/store processor (MIPS-like encoding).
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       synchronous active-low reset
//   pc        current instruction word address
//   inst      instruction at pc, valid in the same cycle
//   mem_addr  data word address = rs + sext(imm16), always driven
//   mem_in    data read at mem_addr, valid in the same cycle
//   mem_out   store data = rt value, always driven
//   we        store strobe; memory commits mem_out at mem_addr on the rising edge
// Optional feature macro: PROC_MUL_EN (R-type funct 0x18 MUL).
module proc_core32 #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_in,
    output logic [XLEN-1:0] mem_out,
    output logic            we
);

    import proc_pkg::*;

    logic [XLEN-1:0]   r_counter;
    logic              r_halted;
    logic [XLEN-1:0]   r_regs [NUM_REGS];

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [15:0]       w_imm;
    logic [25:0]       w_target;

    logic [XLEN-1:0]   w_rs_val;
    logic [XLEN-1:0]   w_rt_val;
    logic [XLEN-1:0]   w_imm_sext;
    logic [XLEN-1:0]   w_imm_zext;
    logic [XLEN-1:0]   w_pc_inc;
    logic [XLEN-1:0]   w_eff_addr;

    alu_op_e           w_alu_op;
    logic [XLEN-1:0]   w_alu_b;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_alu_zero;

    logic              w_wr_en;
    logic [REG_AW-1:0] w_wr_addr;
    logic              w_wr_mem;
    logic [XLEN-1:0]   w_wr_data;
    logic              w_store;
    logic              w_branch_eq;
    logic              w_branch_ne;
    logic              w_jump;
    logic              w_halt;
    logic [XLEN-1:0]   w_next_pc;

    // Instruction fields
    assign w_opcode = inst[OP_HI:OP_LO];
    assign w_funct  = inst[FN_HI:FN_LO];
    assign w_rs     = inst[RS_HI:RS_LO];
    assign w_rt     = inst[RT_HI:RT_LO];
    assign w_rd     = inst[RD_HI:RD_LO];
    assign w_imm    = inst[IMM_HI:IMM_LO];
    assign w_target = inst[TGT_HI:TGT_LO];

    // Register file reads; r0 is hardwired to zero
    assign w_rs_val = (w_rs == '0) ? '0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 : r_regs[w_rt];

    assign w_imm_sext = sext16(w_imm);
    assign w_imm_zext = XLEN'(w_imm);
    assign w_pc_inc   = r_counter + XLEN'(1);
    assign w_eff_addr = w_rs_val + w_imm_sext;

    // Decode: ALU control, register write and memory/control-flow flags
    always_comb begin
        w_alu_op    = ALU_ADD;
        w_alu_b     = w_rt_val;
        w_wr_en     = 1'b0;
        w_wr_addr   = w_rd;
        w_wr_mem    = 1'b0;
        w_store     = 1'b0;
        w_branch_eq = 1'b0;
        w_branch_ne = 1'b0;
        w_jump      = 1'b0;
        w_halt      = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_wr_en = 1'b1;
                case (w_funct)
                    FN_ADD:  w_alu_op = ALU_ADD;
                    FN_SUB:  w_alu_op = ALU_SUB;
                    FN_AND:  w_alu_op = ALU_AND;
                    FN_OR:   w_alu_op = ALU_OR;
                    FN_XOR:  w_alu_op = ALU_XOR;
                    FN_SLT:  w_alu_op = ALU_SLT;
                    FN_SLL:  w_alu_op = ALU_SLL;
                    FN_SRL:  w_alu_op = ALU_SRL;
                    FN_SRA:  w_alu_op = ALU_SRA;
`ifdef PROC_MUL_EN
                    FN_MUL:  w_alu_op = ALU_MUL;
`endif
                    default: w_wr_en  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                w_alu_b   = w_imm_sext;
                w_wr_en   = 1'b1;
                w_wr_addr = w_rt;
            end
            OP_ANDI: begin
                w_alu_op  = ALU_AND;
                w_alu_b   = w_imm_zext;
                w_wr_en   = 1'b1;
                w_wr_addr = w_rt;
            end
            OP_ORI: begin
                w_alu_op  = ALU_OR;
                w_alu_b   = w_imm_zext;
                w_wr_en   = 1'b1;
                w_wr_addr = w_rt;
            end
            OP_LUI: begin
                w_alu_op  = ALU_PASS_B;
                w_alu_b   = {w_imm, 16'h0000};
                w_wr_en   = 1'b1;
                w_wr_addr = w_rt;
            end
            OP_LW: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_rt;
                w_wr_mem  = 1'b1;
            end
            OP_SW: begin
                w_store = 1'b1;
            end
            OP_BEQ: begin
                w_alu_op    = ALU_SUB;
                w_branch_eq = 1'b1;
            end
            OP_BNE: begin
                w_alu_op    = ALU_SUB;
                w_branch_ne = 1'b1;
            end
            OP_J: begin
                w_jump = 1'b1;
            end
            OP_HALT: begin
                w_halt = 1'b1;
            end
            default: begin
                // Undefined opcode: NOP
            end
        endcase
    end

    // Next-PC selection; kept apart from decode so the ALU zero flag feeds forward only
    always_comb begin
        w_next_pc = w_pc_inc;
        if ((w_branch_eq && w_alu_zero) || (w_branch_ne && !w_alu_zero)) begin
            w_next_pc = w_pc_inc + w_imm_sext;
        end else if (w_jump) begin
            w_next_pc = {r_counter[XLEN-1:26], w_target};
        end else if (w_halt) begin
            w_next_pc = r_counter;
        end
    end

    proc_alu u_alu (
        .i_a        (w_rs_val),
        .i_b        (w_alu_b),
        .i_alu_op   (w_alu_op),
        .o_result_c (w_alu_result),
        .o_zero_c   (w_alu_zero)
    );

    assign w_wr_data = w_wr_mem ? mem_in : w_alu_result;

    // Outputs are combinational from state and the current instruction
    assign pc       = r_counter;
    assign mem_addr = w_eff_addr;
    assign mem_out  = w_rt_val;
    assign we       = rst && w_store && !r_halted;

    // PC, halt flag and register file commit; a halted core freezes until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_counter <= RESET_PC;
            r_halted  <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (!r_halted) begin
            r_counter <= w_next_pc;
            r_halted  <= w_halt;
            if (w_wr_en && (w_wr_addr != '0)) begin
                r_regs[w_wr_addr] <= w_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_proc_core32.sv
// Self-checking bench for proc_core32: directed programs from the test plan plus
// randomized instruction streams, compared cycle by cycle against an
// instruction-level model of the architecture.
module tb_proc_core32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        we;

    logic [31:0] imem [64];
    logic [31:0] dmem [256];

    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [256];
    logic [31:0] m_pc;
    bit          m_halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    proc_core32 dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .inst     (inst),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_out  (mem_out),
        .we       (we)
    );

    assign inst   = imem[pc[5:0]];
    assign mem_in = dmem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (we) dmem[mem_addr[7:0]] <= mem_out;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic m_reset();
        m_pc = 32'h0;
        m_halted = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 32'h0;
            m_dmem[i] = 32'h0;
        end
    endtask

    // One clock: compare outputs against the model, advance the model, advance the DUT.
    // Called and returns at the falling edge.
    task automatic step(input logic rst_v);
        logic [31:0] ins, a, b, sx, zx, addr, res, npc;
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        int          rs, rt, rd, wreg;
        bit          wr, st, hlt;
        rst  = rst_v;
        ins  = imem[m_pc[5:0]];
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        a    = m_regs[rs];
        b    = m_regs[rt];
        sh   = b[4:0];
        sx   = {{16{ins[15]}}, ins[15:0]};
        zx   = {16'h0000, ins[15:0]};
        addr = a + sx;
        st   = rst_v && !m_halted && (op == 6'h2B);
        #1;
        check_eq("pc", pc, m_pc);
        check_eq("we", {31'b0, we}, {31'b0, st});
        check_eq("mem_addr", mem_addr, addr);
        check_eq("mem_out", mem_out, b);

        npc = m_pc + 32'd1;
        wr = 1'b0; wreg = rt; res = 32'h0; hlt = 1'b0;
        case (op)
            6'h00: begin
                wr = 1'b1; wreg = rd;
                case (fn)
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: res = a << sh;
                    6'h02: res = a >> sh;
                    6'h03: res = a[31] ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
`ifdef PROC_MUL_EN
                    6'h18: res = a * b;
`endif
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin wr = 1'b1; res = a + sx; end
            6'h0C: begin wr = 1'b1; res = a & zx; end
            6'h0D: begin wr = 1'b1; res = a | zx; end
            6'h0F: begin wr = 1'b1; res = {ins[15:0], 16'h0000}; end
            6'h23: begin wr = 1'b1; res = m_dmem[addr[7:0]]; end
            6'h04: if (a == b) npc = m_pc + 32'd1 + sx;
            6'h05: if (a != b) npc = m_pc + 32'd1 + sx;
            6'h02: npc = {m_pc[31:26], ins[25:0]};
            6'h3F: begin npc = m_pc; hlt = 1'b1; end
            default: ;
        endcase

        if (!rst_v) begin
            m_reset();
        end else if (!m_halted) begin
            if (st) m_dmem[addr[7:0]] = b;
            if (wr && wreg != 0) m_regs[wreg] = res;
            m_pc = npc;
            m_halted = hlt;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        int          k, rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  fn;
        k   = int'($urandom_range(0, 19));
        rs  = int'($urandom_range(0, 7));
        rt  = int'($urandom_range(0, 7));
        rd  = int'($urandom_range(0, 7));
        imm = 16'($urandom);
        case (k)
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h26;
            5: fn = 6'h2A;
            6: fn = 6'h00;
            7: fn = 6'h02;
            8: fn = 6'h03;
            9: fn = 6'h18;
            default: fn = 6'h3B;
        endcase
        case (k)
            10: return enc_i(6'h08, rt, rs, imm);
            11: return enc_i(6'h0C, rt, rs, imm);
            12: return enc_i(6'h0D, rt, rs, imm);
            13: return enc_i(6'h0F, rt, rs, imm);
            14: return enc_i(6'h23, rt, rs, imm);
            15: return enc_i(6'h2B, rt, rs, imm);
            16: return enc_i(6'h04, rt, rs, 16'($urandom_range(0, 8)) - 16'd4);
            17: return enc_i(6'h05, rt, rs, 16'($urandom_range(0, 8)) - 16'd4);
            18: return {6'h02, 26'($urandom_range(0, 63))};
            19: begin
                case ($urandom_range(0, 4))
                    0: return {6'h3F, 26'h0};
                    1: return enc_i(6'h11, rt, rs, imm);
                    2: return enc_i(6'h3E, rt, rs, imm);
                    default: return enc_r(fn, rd, rs, rt);
                endcase
            end
            default: return enc_r(fn, rd, rs, rt);
        endcase
    endfunction

    task automatic do_reset();
        step(1'b0);
        check_eq("reset_pc", pc, 32'h0);
    endtask

    initial begin
        logic [31:0] exp21, exp22;
        rst = 1'b0;
        clear_mem();
        @(posedge clk);
        @(negedge clk);
        m_reset();

        // Reset held a second cycle, then NOP execution
        step(1'b0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_we", {31'b0, we}, 32'h0);
        step(1'b1);
        check_eq("nop_pc1", pc, 32'd1);
        step(1'b1);
        check_eq("nop_pc2", pc, 32'd2);

        // ALU chain
        clear_mem();
        imem[0] = enc_i(6'h08, 1, 0, 16'd5);
        imem[1] = enc_i(6'h08, 2, 0, 16'hFFFD);
        imem[2] = enc_r(6'h20, 3, 1, 2);
        imem[3] = enc_r(6'h22, 4, 2, 1);
        imem[4] = enc_r(6'h2A, 5, 2, 1);
        imem[5] = enc_i(6'h2B, 3, 0, 16'd16);
        imem[6] = enc_i(6'h2B, 4, 0, 16'd17);
        imem[7] = enc_i(6'h2B, 5, 0, 16'd18);
        imem[8] = {6'h3F, 26'h0};
        do_reset();
        repeat (12) step(1'b1);
        check_eq("alu_r3", dmem[16], 32'd2);
        check_eq("alu_r4", dmem[17], 32'hFFFF_FFF8);
        check_eq("alu_r5", dmem[18], 32'd1);

        // Store / load
        clear_mem();
        imem[0] = enc_i(6'h08, 1, 0, 16'h0100);
        imem[1] = enc_i(6'h2B, 1, 0, 16'd4);
        imem[2] = enc_i(6'h23, 6, 0, 16'd4);
        imem[3] = enc_i(6'h2B, 6, 0, 16'd5);
        imem[4] = {6'h3F, 26'h0};
        do_reset();
        check_eq("mem_we_pre", {31'b0, we}, 32'h0);
        step(1'b1);
        check_eq("sw_we", {31'b0, we}, 32'd1);
        check_eq("sw_addr", mem_addr, 32'd4);
        check_eq("sw_data", mem_out, 32'h100);
        step(1'b1);
        check_eq("lw_we", {31'b0, we}, 32'h0);
        repeat (6) step(1'b1);
        check_eq("sw_mem", dmem[4], 32'h100);
        check_eq("lw_r6", dmem[5], 32'h100);

        // Control flow
        clear_mem();
        imem[10] = enc_i(6'h04, 0, 0, 16'd2);
        imem[13] = enc_i(6'h05, 0, 0, 16'd2);
        imem[14] = {6'h02, 26'h20};
        do_reset();
        repeat (10) step(1'b1);
        check_eq("pre_beq", pc, 32'd10);
        step(1'b1);
        check_eq("beq_taken", pc, 32'd13);
        step(1'b1);
        check_eq("bne_fall", pc, 32'd14);
        step(1'b1);
        check_eq("jump", pc, 32'h20);
        repeat (3) step(1'b1);

        // HALT
        clear_mem();
        imem[7] = {6'h3F, 26'h0};
        do_reset();
        repeat (7) step(1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            check_eq("halt_pc", pc, 32'd7);
            check_eq("halt_we", {31'b0, we}, 32'h0);
        end
        step(1'b0);
        check_eq("halt_reset", pc, 32'h0);

        // r0 protection and MUL
        clear_mem();
        imem[0]  = enc_i(6'h08, 0, 0, 16'd9);
        imem[1]  = enc_r(6'h20, 7, 0, 0);
        imem[2]  = enc_i(6'h2B, 7, 0, 16'd20);
        imem[3]  = enc_i(6'h0F, 1, 0, 16'd1);
        imem[4]  = enc_i(6'h08, 2, 0, 16'h0077);
        imem[5]  = enc_r(6'h18, 2, 1, 1);
        imem[6]  = enc_i(6'h2B, 2, 0, 16'd21);
        imem[7]  = enc_i(6'h08, 3, 0, 16'd7);
        imem[8]  = enc_i(6'h08, 4, 0, 16'd6);
        imem[9]  = enc_i(6'h08, 5, 0, 16'h0055);
        imem[10] = enc_r(6'h18, 5, 3, 4);
        imem[11] = enc_i(6'h2B, 5, 0, 16'd22);
        imem[12] = {6'h3F, 26'h0};
        do_reset();
        repeat (16) step(1'b1);
`ifdef PROC_MUL_EN
        exp21 = 32'h0;
        exp22 = 32'd42;
`else
        exp21 = 32'h77;
        exp22 = 32'h55;
`endif
        check_eq("r0_protect", dmem[20], 32'h0);
        check_eq("mul_wide", dmem[21], exp21);
        check_eq("mul_small", dmem[22], exp22);

        // Randomized programs with occasional mid-run resets
        for (int r = 0; r < 4; r++) begin
            clear_mem();
            for (int i = 0; i < 64; i++) imem[i] = rand_inst();
            for (int i = 0; i < 256; i++) begin
                dmem[i] = $urandom;
                m_dmem[i] = dmem[i];
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
                step(($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_core32.md
Name: proc_core32

Overview:
- Single-cycle 32-bit word-addressed load/store processor (MIPS-like encoding).
- Drives `pc` to an external instruction memory and receives `inst` combinationally in the same cycle.
- Data memory is a single port: `mem_addr`/`mem_in` for combinational read, `mem_out`/`we` for writes committed by the memory at the clock edge.
- Top-level CPU of the system; the memory lives outside the block.

Parameters:
- XLEN, 32, datapath/address/instruction width.
- RESET_PC, 32'h0000_0000, word address loaded into the PC at reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- pc  out  XLEN  current instruction word address (the PC register, named `counter` internally).
- inst  in  XLEN  instruction at `pc`, valid same cycle.
- mem_addr  out  XLEN  data word address = rs + sext(imm16).
- mem_in  in  XLEN  data read at `mem_addr`, valid same cycle.
- mem_out  out  XLEN  store data = rt value.
- we  out  1  store strobe; memory writes `mem_out` at `mem_addr` on the rising edge while high.

Behaviour:
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm16 [15:0], target26 [25:0].
- 32x32 register file; r0 reads 0 and ignores writes. Two combinational reads, one write per rising edge.
- One instruction per cycle. PC and register write commit at the rising edge. Default next PC = pc+1 (word addressing, wraps at 2^32).
- Opcode 0x00 (R-type), result to rd, selected by funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR: rd = rs op rt (ADD/SUB wrap mod 2^32, no overflow trap).
  - 0x2A SLT: rd = 1 if signed rs < rt, else 0.
  - 0x00 SLL: rd = rs << rt[4:0].
  - 0x02 SRL: rd = rs >> rt[4:0], logical.
  - 0x03 SRA: rd = rs >> rt[4:0], arithmetic.
- I-type, result to rt:
  - 0x08 ADDI: rt = rs + sext(imm).
  - 0x0C ANDI, 0x0D ORI: zero-extended immediate.
  - 0x0F LUI: rt = {imm, 16'h0}.
  - 0x23 LW: rt = mem_in, with mem_addr = rs + sext(imm).
- 0x2B SW: we = 1, mem_out = rt, no register write.
- 0x04 BEQ / 0x05 BNE: if the condition holds, next PC = pc + 1 + sext(imm); else pc+1.
- 0x02 J: next PC = {pc[31:26], target26}.
- 0x3F HALT: PC holds, no writes; stays halted until reset.
- Any undefined opcode or funct executes as a NOP: PC+1, no writes.
- Reset (rst==0 at rising edge): counter <= RESET_PC, all registers <= 0, halted flag cleared.
- While rst is low, `we` is forced to 0 combinationally and no register write occurs. Reset asserted mid-instruction aborts it.
- Outputs are combinational from state+inst.
  - When the instruction is not LW/SW, mem_addr and mem_out still show rs+sext(imm) and rt, with we = 0.
- Writing r0 (e.g. LW into r0) performs the memory read but discards the result.

Optional Feature:
- Macro PROC_MUL_EN.
- Defined: R-type funct 0x18 MUL, rd = low 32 bits of rs*rt, same single cycle.
- Undefined: funct 0x18 behaves as an undefined NOP and no multiplier is synthesized.

Decomposition:
- Package proc_pkg: XLEN, opcode and funct constants, field bit positions, ALU-op enumeration typedef.
- One sub-module, proc_alu: combinational, takes a, b, alu_op and produces result and zero.
- Register file, decode and next-PC logic stay in proc_core32.

Test Plan:
- Reset: hold rst=0 two cycles, release.
  - pc=0 and we=0 during reset.
  - pc sequence 0,1,2 afterwards on NOP memory (all zeros = SLL r0).
- ALU chain: ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; SUB r4,r2,r1; SLT r5,r2,r1.
  - r3=2, r4=0xFFFFFFF8, r5=1.
- Memory: ADDI r1,r0,0x100; SW r1,4(r0); LW r6,4(r0).
  - we=1 for exactly one cycle with mem_addr=4 and mem_out=0x100.
  - r6=0x100.
- Control: BEQ r0,r0,+2 at pc=10 → next pc=13; BNE r0,r0,+2 → pc+1; J 0x20 → pc=0x20.
- HALT at pc=7: pc stays 7 for 10 cycles with we=0; then rst=0 one cycle → pc=0.
- r0 protection and MUL: ADDI r0,r0,9 then ADD r7,r0,r0 → r7=0.
  - With PROC_MUL_EN: MUL of 0x10000 by 0x10000 → 0.
  - With PROC_MUL_EN: MUL of 7 by 6 → 42.
  - Without PROC_MUL_EN: the MUL leaves rd unchanged.
